zaxis_extreme_reduce_n: RTL

// - Parametrised successor to the 4-scale z-axis max finder: pipelined extreme-value reduction across P_NUM_CH scale streams.
// - Supports runtime max/min mode, a per-frame channel mask and signed or unsigned compare.
// - Argmax output (winning channel index) is optional.
// - Sits after the multi-scale filter bank and before the detection threshold stage of the infrared pipeline.

---
 rtl/zaxis_extreme_reduce_n.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/zaxis_extreme_reduce_n.sv
// Pipelined max/min reduction across P_NUM_CH scale streams with frame-latched mode and channel mask.
// Define ZAXIS_ARGMAX_EN to carry the winning channel index through the tree onto o_idx.
module zaxis_extreme_reduce_n #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_NUM_CH     = 4,
  parameter int P_IDX_WIDTH  = 3,
  parameter bit P_SIGNED     = 1'b0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [P_NUM_CH-1:0]              i_v_sync,
  input  logic [P_NUM_CH-1:0]              i_h_sync,
  input  logic [P_NUM_CH*P_DATA_WIDTH-1:0] i_data,
  input  logic                             i_mode,
  input  logic [P_NUM_CH-1:0]              i_ch_mask,
  output logic                             o_v_sync,
  output logic                             o_h_sync,
  output logic [P_DATA_WIDTH-1:0]          o_data,
  output logic [P_IDX_WIDTH-1:0]           o_idx,
  output logic                             o_sync_err
);

  localparam int W = P_DATA_WIDTH;
  localparam int N = P_NUM_CH;
  localparam int L = $clog2(P_NUM_CH);

  function automatic int levelCount(input int lvl);
    return (N + (1 << lvl) - 1) >> lvl;
  endfunction

  // The right-hand (higher index) leaf only wins on a strict improvement, so ties keep the lower index.
  function automatic logic takeRight(input logic [W-1:0] a, input logic aVld,
                                     input logic [W-1:0] b, input logic bVld,
                                     input logic minMode);
    logic bAbove;
    logic bBelow;
    if (P_SIGNED) begin
      bAbove = $signed(b) > $signed(a);
      bBelow = $signed(b) < $signed(a);
    end else begin
      bAbove = b > a;
      bBelow = b < a;
    end
    if (!bVld) return 1'b0;
    if (!aVld) return 1'b1;
    return minMode ? bBelow : bAbove;
  endfunction

  logic [N-1:0]   vSync_q, hSync_q, mask_q, maskLat_q;
  logic [N*W-1:0] data_q;
  logic           mode_q, modeLat_q, vPrev_q;

  logic           vAll, hAll, frameStart, effMode, errNow, errSticky, anyHigh;
  logic [N-1:0]   effMask, hMasked;

  logic [L-1:0]   vPipe_q, hPipe_q, errPipe_q, modePipe_q;
  logic [W-1:0]   tData_q [L][N];
  logic [W-1:0]   tData_d [L][N];
  logic           tVld_q  [L][N];
  logic           tVld_d  [L][N];
`ifdef ZAXIS_ARGMAX_EN
  logic [P_IDX_WIDTH-1:0] tIdx_q [L][N];
  logic [P_IDX_WIDTH-1:0] tIdx_d [L][N];
`endif

  // The first pixel of a frame must already use the freshly sampled mode and mask.
  assign vAll       = &vSync_q;
  assign frameStart = vAll & ~vPrev_q;
  assign effMode    = frameStart ? mode_q : modeLat_q;
  assign effMask    = frameStart ? mask_q : maskLat_q;
  assign hMasked    = hSync_q | ~effMask;
  assign anyHigh    = |(hSync_q & effMask);
  assign hAll       = vAll & (&hMasked);
  assign errNow     = vAll & anyHigh & ~(&hMasked);
  assign errSticky  = frameStart ? errNow : (errPipe_q[0] | errNow);

  always_comb begin
    logic [W-1:0] curData [N];
    logic         curVld  [N];
    logic         curMode;
    logic         curH;
    int           ia;
    int           ib;
    int           nIn;
`ifdef ZAXIS_ARGMAX_EN
    logic [P_IDX_WIDTH-1:0] curIdx [N];
`endif
    for (int i = 0; i < N; i++) begin
      curData[i] = data_q[i*W +: W];
      curVld[i]  = effMask[i];
`ifdef ZAXIS_ARGMAX_EN
      curIdx[i]  = P_IDX_WIDTH'(i);
`endif
    end
    curMode = effMode;
    curH    = hAll;
    for (int l = 0; l < L; l++) begin
      nIn = levelCount(l);
      for (int i = 0; i < N; i++) begin
        ia = (2*i < N) ? 2*i : 0;
        ib = (2*i+1 < N) ? 2*i+1 : 0;
        tData_d[l][i] = '0;
        tVld_d[l][i]  = 1'b0;
`ifdef ZAXIS_ARGMAX_EN
        tIdx_d[l][i]  = '0;
`endif
        if (2*i+1 < nIn) begin
          if (takeRight(curData[ia], curVld[ia], curData[ib], curVld[ib], curMode)) begin
            tData_d[l][i] = curData[ib];
`ifdef ZAXIS_ARGMAX_EN
            tIdx_d[l][i]  = curIdx[ib];
`endif
          end else begin
            tData_d[l][i] = curData[ia];
`ifdef ZAXIS_ARGMAX_EN
            tIdx_d[l][i]  = curIdx[ia];
`endif
          end
          tVld_d[l][i] = curVld[ia] | curVld[ib];
        end else if (2*i < nIn) begin
          tData_d[l][i] = curData[ia];
          tVld_d[l][i]  = curVld[ia];
`ifdef ZAXIS_ARGMAX_EN
          tIdx_d[l][i]  = curIdx[ia];
`endif
        end
      end
      // The last level is the output register: blank it outside valid pixels or when nothing participated.
      if (l == L-1 && !(curH && tVld_d[l][0])) begin
        tData_d[l][0] = '0;
`ifdef ZAXIS_ARGMAX_EN
        tIdx_d[l][0]  = '0;
`endif
      end
      for (int i = 0; i < N; i++) begin
        curData[i] = tData_q[l][i];
        curVld[i]  = tVld_q[l][i];
`ifdef ZAXIS_ARGMAX_EN
        curIdx[i]  = tIdx_q[l][i];
`endif
      end
      curMode = modePipe_q[l];
      curH    = hPipe_q[l];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vSync_q    <= '0;
      hSync_q    <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      vPrev_q    <= 1'b0;
      modeLat_q  <= 1'b0;
      maskLat_q  <= '1;
      vPipe_q    <= '0;
      hPipe_q    <= '0;
      errPipe_q  <= '0;
      modePipe_q <= '0;
      for (int l = 0; l < L; l++) begin
        for (int i = 0; i < N; i++) begin
          tData_q[l][i] <= '0;
          tVld_q[l][i]  <= 1'b0;
`ifdef ZAXIS_ARGMAX_EN
          tIdx_q[l][i]  <= '0;
`endif
        end
      end
    end else begin
      vSync_q <= i_v_sync;
      hSync_q <= i_h_sync;
      mask_q  <= i_ch_mask;
      data_q  <= i_data;
      mode_q  <= i_mode;
      vPrev_q <= vAll;
      if (frameStart) begin
        modeLat_q <= mode_q;
        maskLat_q <= mask_q;
      end
      vPipe_q[0]    <= vAll;
      hPipe_q[0]    <= hAll;
      errPipe_q[0]  <= errSticky;
      modePipe_q[0] <= effMode;
      for (int l = 1; l < L; l++) begin
        vPipe_q[l]    <= vPipe_q[l-1];
        hPipe_q[l]    <= hPipe_q[l-1];
        errPipe_q[l]  <= errPipe_q[l-1];
        modePipe_q[l] <= modePipe_q[l-1];
      end
      for (int l = 0; l < L; l++) begin
        for (int i = 0; i < N; i++) begin
          tData_q[l][i] <= tData_d[l][i];
          tVld_q[l][i]  <= tVld_d[l][i];
`ifdef ZAXIS_ARGMAX_EN
          tIdx_q[l][i]  <= tIdx_d[l][i];
`endif
        end
      end
    end
  end

  assign o_v_sync   = vPipe_q[L-1];
  assign o_h_sync   = hPipe_q[L-1];
  assign o_sync_err = errPipe_q[L-1];
  assign o_data     = tData_q[L-1][0];
`ifdef ZAXIS_ARGMAX_EN
  assign o_idx      = tIdx_q[L-1][0];
`else
  assign o_idx      = '0;
`endif

endmodule
